// File: rtl/uart_pkg.sv
// Shared types and UART timing constants for the transmitter arbiter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, FRAME} tx_arb_state_t;

  localparam int UART_CLKS_PER_BIT = 10417;
  localparam int UART_FRAME_BITS   = 10;

  // Clock cycles occupied by one frame plus its trailing guard time.
  function automatic int slot_cycles(input int frame_bits, input int guard_bits,
                                     input int clks_per_bit);
    return (frame_bits + guard_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search; the search begins one past ptr_i and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] index_o,
  output logic          any_o
);

  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        index_o      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers;
// each accepted byte owns the transmitter for one fixed-length frame slot.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FRAME_BITS   = UART_FRAME_BITS,
  parameter int GUARD_BITS   = 1
) (
  input  logic                       input_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       trans_en,
  output logic [7:0]                 data_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int SLOT = slot_cycles(FRAME_BITS, GUARD_BITS, CLKS_PER_BIT);
  localparam int CW   = $clog2(SLOT);

  tx_arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [7:0]    data_q, data_d;

  logic [NUM_REQ-1:0] win_grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .index_o (win_idx),
    .any_o   (win_any)
  );

  // The slot counter runs continuously across START and FRAME, so it reads
  // 0..SLOT-1 over the slot and both phase boundaries are simple compares.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    data_d     = data_q;
    req_ready  = '0;
    trans_en   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset && win_any) begin
          req_ready = win_grant;
          data_d    = req_data[int'(win_idx)*8 +: 8];
          gid_d     = win_idx;
          ptr_d     = win_idx;
          cnt_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        trans_en = 1'b1;
        busy     = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) state_d = FRAME;
      end
      FRAME: begin
        busy = 1'b1;
        if (cnt_q == CW'(SLOT - 1)) begin
          frame_done = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a short bit time (SLOT = 44 cycles).
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int CPB  = 4;
  localparam int SLOT = 44;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         trans_en;
  logic [7:0]   data_out;
  logic         busy;
  logic [1:0]   grant_id;
  logic         frame_done;

  uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .FRAME_BITS(10), .GUARD_BITS(1)) dut (
    .input_clk (clk),
    .reset     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .trans_en  (trans_en),
    .data_out  (data_out),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int m_state = 0, m_cnt = 0, m_ptr = N - 1, m_data = 0, m_gid = 0;
  int sb[$];
  int obs_id[$];
  int obs_cyc[$];
  int obs_fd_gap[$];
  int last_fd = -1000;
  int busy_n = 0, te_n = 0, fd_n = 0;
  logic prev_te = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int oid(input int k);
    return (k < obs_id.size()) ? obs_id[k] : -1;
  endfunction

  function automatic int ocyc(input int k);
    return (k < obs_cyc.size()) ? obs_cyc[k] : -1;
  endfunction

  task automatic step();
    int win, exp_rdy, e;
    #1;
    win = -1;
    if (rst_n && m_state == 0)
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    exp_rdy = (win >= 0) ? (1 << win) : 0;
    chk("req_ready", int'(req_ready), exp_rdy);
    chk("trans_en", int'(trans_en), int'(m_state == 1));
    chk("busy", int'(busy), int'(m_state != 0));
    chk("frame_done", int'(frame_done), int'(m_state == 2 && m_cnt == SLOT - 1));
    chk("data_out", int'(data_out), m_data);
    chk("grant_id", int'(grant_id), m_gid);
    if (busy) busy_n++;
    if (trans_en) te_n++;
    if (frame_done) begin fd_n++; last_fd = cyc; end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        obs_id.push_back(i);
        obs_cyc.push_back(cyc);
        obs_fd_gap.push_back(cyc - last_fd);
      end
    if (trans_en && !prev_te) begin
      if (sb.size() == 0) chk("sb_empty_pop", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_slot", int'(grant_id) * 256 + int'(data_out), e);
      end
    end
    prev_te = trans_en;
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_ptr = N - 1; m_data = 0; m_gid = 0;
    end else begin
      case (m_state)
        0: if (win >= 0) begin
             m_data = int'(req_data[win*8 +: 8]);
             m_gid = win; m_ptr = win; m_state = 1; m_cnt = 0;
             sb.push_back(win * 256 + m_data);
           end
        1: begin if (m_cnt == CPB - 1) m_state = 2; m_cnt++; end
        default: if (m_cnt == SLOT - 1) begin m_state = 0; m_cnt = 0; end else m_cnt++;
      endcase
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    obs_id.delete(); obs_cyc.delete(); obs_fd_gap.delete();
    busy_n = 0; te_n = 0; fd_n = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = 32'h33221100;
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(data_out), 0);

    // single requester 2
    clear_obs();
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    run(50);
    chk("s1_grants", obs_id.size(), 1);
    chk("s1_id", oid(0), 2);
    chk("s1_busy_cycles", busy_n, 44);
    chk("s1_te_cycles", te_n, 4);
    chk("s1_fd_pulses", fd_n, 1);
    chk("s1_data", int'(data_out), 8'hA5);
    chk("s1_gid", int'(grant_id), 2);

    // all valid after reset: order 0,1,2,3,0 with 45-cycle spacing
    rst_n = 1'b0; step(); rst_n = 1'b1;
    clear_obs();
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    run(5 * 45);
    req_valid = '0;
    run(50);
    for (int k = 0; k < 5; k++) chk("s2_order", oid(k), k % 4);
    for (int k = 1; k < 5; k++) chk("s2_spacing", ocyc(k) - ocyc(k - 1), 45);

    // late arrival waits for the slot to end
    clear_obs();
    req_data = 32'h00002A1B;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    run(10);
    req_valid = 4'b0010;
    run(50);
    req_valid = '0;
    run(50);
    chk("s3_grants", obs_id.size(), 2);
    chk("s3_id", oid(1), 1);
    chk("s3_gap_fd", (obs_fd_gap.size() > 1) ? obs_fd_gap[1] : -1, 1);
    chk("s3_gap_grant", ocyc(1) - ocyc(0), 45);

    // reset mid-FRAME abandons the slot; requester 0 then has priority
    clear_obs();
    req_data = 32'hC4000077;
    req_valid = 4'b1000;
    step();
    run(20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("s4_busy", int'(busy), 0);
    chk("s4_te", int'(trans_en), 0);
    chk("s4_data", int'(data_out), 0);
    req_valid = 4'b1001;
    step();
    req_valid = 4'b1000;
    run(46);
    req_valid = '0;
    run(50);
    chk("s4_first", oid(0), 3);
    chk("s4_after_rst", oid(1), 0);
    chk("s4_next", oid(2), 3);

    // pointer at 3 wraps to 0 before 3 again
    clear_obs();
    req_valid = 4'b1001;
    run(91);
    req_valid = '0;
    run(50);
    chk("s6_wrap", oid(0), 0);
    chk("s6_then", oid(1), 3);
    chk("sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
